// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the core's data-memory port.
// DEPTH x 32-bit synchronous SRAM model. Reads have one cycle of latency
// through the Q register. OEN gates the output combinationally.
// Saturating read/write counters and a sticky out-of-range flag are
// provided for observation.
module data_mem_responder #(
   parameter int DEPTH = 128,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             CEN,
   input  logic             WEN,
   input  logic [6:0]       A,
   input  logic [31:0]      Data2Mem,
   input  logic             OEN,
   output logic [31:0]      ReadDataMem,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt,
   output logic             addr_err
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] DEPTH_L = 8'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [31:0]   q;
   logic          in_range;
   logic          acc_rd;
   logic          acc_wr;
   logic [AW-1:0] idx;

   // An unknown CEN/WEN makes these evaluate false, so that cycle behaves as idle.
   assign acc_rd   = (CEN == 1'b0) && (WEN == 1'b1);
   assign acc_wr   = (CEN == 1'b0) && (WEN == 1'b0);
   assign in_range = ({1'b0, A} < DEPTH_L);
   assign idx      = A[AW-1:0];

   // Storage array. An out-of-range write is dropped, so no word is aliased.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (acc_wr && in_range) begin
         mem[idx] <= Data2Mem;
      end
   end

   // Output register. Q loads only on a read; a write leaves Q unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (acc_rd) begin
         q <= in_range ? mem[idx] : 32'h0;
      end
   end

   // Saturating access counters. Out-of-range accesses are counted as well.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (acc_rd && (rd_cnt != {CNT_W{1'b1}})) begin
            rd_cnt <= rd_cnt + 1'b1;
         end
         if (acc_wr && (wr_cnt != {CNT_W{1'b1}})) begin
            wr_cnt <= wr_cnt + 1'b1;
         end
      end
   end

   // Sticky out-of-range flag. Only rst clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_err <= 1'b0;
      end else if ((acc_rd || acc_wr) && !in_range) begin
         addr_err <= 1'b1;
      end
   end

   // The output-enable gate is purely combinational and does not touch Q.
   assign ReadDataMem = (OEN == 1'b0) ? q : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder, instantiated with DEPTH=64 and CNT_W=4.
// The reference model keeps the memory as a plain array and the access
// counts as unbounded integers. Saturation and the out-of-range rule are
// applied to the model when the expected outputs are formed.
module tb_data_mem_responder;

   localparam int DEPTH = 64;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             CEN;
   logic             WEN;
   logic [6:0]       A;
   logic [31:0]      Data2Mem;
   logic             OEN;
   logic [31:0]      ReadDataMem;
   logic [CNT_W-1:0] rd_cnt;
   logic [CNT_W-1:0] wr_cnt;
   logic             addr_err;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_q;
   int          m_rd;
   int          m_wr;
   bit          m_err;

   data_mem_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .CEN         (CEN),
      .WEN         (WEN),
      .A           (A),
      .Data2Mem    (Data2Mem),
      .OEN         (OEN),
      .ReadDataMem (ReadDataMem),
      .rd_cnt      (rd_cnt),
      .wr_cnt      (wr_cnt),
      .addr_err    (addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      m_q   = 32'h0;
      m_rd  = 0;
      m_wr  = 0;
      m_err = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".rdata"}, ReadDataMem, OEN ? 32'h0 : m_q);
      chk({tag, ".rd_cnt"}, 32'(rd_cnt), 32'((m_rd > CMAX) ? CMAX : m_rd));
      chk({tag, ".wr_cnt"}, 32'(wr_cnt), 32'((m_wr > CMAX) ? CMAX : m_wr));
      chk({tag, ".addr_err"}, 32'(addr_err), 32'(m_err));
   endtask

   // One clock cycle with the given request. The outputs are checked 1 ns after the edge.
   task automatic cyc(input string tag, input logic cen, input logic wen,
                      input logic [6:0] a, input logic [31:0] d, input logic oen);
      CEN = cen; WEN = wen; A = a; Data2Mem = d; OEN = oen;
      @(posedge clk);
      #1;
      if (!cen) begin
         if (!wen) begin
            if (a < DEPTH) m_mem[a] = d;
            m_wr++;
         end else begin
            m_q = (a < DEPTH) ? m_mem[a] : 32'h0;
            m_rd++;
         end
         if (a >= DEPTH) m_err = 1'b1;
      end
      check_all(tag);
   endtask

   // Reset is asserted mid-cycle. A write is presented on the edge that falls
   // inside reset, and that write must be discarded.
   task automatic apply_rst();
      @(negedge clk);
      rst = 1'b1;
      CEN = 1'b0; WEN = 1'b0; A = 7'd5; Data2Mem = $urandom;
      #1;
      model_reset();
      check_all("rst_async");
      @(posedge clk);
      #1;
      check_all("rst_hold");
      @(negedge clk);
      CEN = 1'b1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_all("rst_release");
   endtask

   initial begin
      rst = 1'b1; CEN = 1'b1; WEN = 1'b1; A = '0; Data2Mem = '0; OEN = 1'b0;
      model_reset();
      #2;
      check_all("por");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // reset wipes memory and outputs
      cyc("w5", 1'b0, 1'b0, 7'd5, 32'hDEADBEEF, 1'b0);
      cyc("r5", 1'b0, 1'b1, 7'd5, 32'h0, 1'b0);
      chk("r5_lit", ReadDataMem, 32'hDEADBEEF);
      apply_rst();
      cyc("r5_after_rst", 1'b0, 1'b1, 7'd5, 32'h0, 1'b0);
      chk("r5_after_rst_lit", ReadDataMem, 32'h0);

      // write then read, output gating and hold
      apply_rst();
      cyc("w3", 1'b0, 1'b0, 7'd3, 32'h12345678, 1'b0);
      cyc("r3", 1'b0, 1'b1, 7'd3, 32'h0, 1'b0);
      chk("r3_lit", ReadDataMem, 32'h12345678);
      chk("r3_rdcnt", 32'(rd_cnt), 32'd1);
      chk("r3_wrcnt", 32'(wr_cnt), 32'd1);
      OEN = 1'b1; #1;
      check_all("oen_off");
      chk("oen_off_lit", ReadDataMem, 32'h0);
      for (int i = 0; i < 3; i++) cyc("idle", 1'b1, 1'b1, 7'($urandom), $urandom, 1'b1);
      OEN = 1'b0; #1;
      check_all("oen_on");
      chk("oen_on_lit", ReadDataMem, 32'h12345678);

      // a write must not disturb Q
      cyc("r3b", 1'b0, 1'b1, 7'd3, 32'h0, 1'b0);
      cyc("w7", 1'b0, 1'b0, 7'd7, 32'hAAAA5555, 1'b0);
      chk("w7_hold_lit", ReadDataMem, 32'h12345678);
      cyc("r7", 1'b0, 1'b1, 7'd7, 32'h0, 1'b0);
      chk("r7_lit", ReadDataMem, 32'hAAAA5555);

      // out-of-range accesses
      apply_rst();
      cyc("w100", 1'b0, 1'b0, 7'd100, 32'hFFFFFFFF, 1'b0);
      chk("w100_err_lit", 32'(addr_err), 32'd1);
      chk("w100_wr_lit", 32'(wr_cnt), 32'd1);
      cyc("r100", 1'b0, 1'b1, 7'd100, 32'h0, 1'b0);
      chk("r100_lit", ReadDataMem, 32'h0);
      cyc("r36", 1'b0, 1'b1, 7'd36, 32'h0, 1'b0);
      chk("r36_lit", ReadDataMem, 32'h0);
      cyc("w36", 1'b0, 1'b0, 7'd36, 32'h13572468, 1'b0);
      cyc("w100b", 1'b0, 1'b0, 7'd100, 32'hFFFFFFFF, 1'b0);
      cyc("r36b", 1'b0, 1'b1, 7'd36, 32'h0, 1'b0);
      chk("r36b_lit", ReadDataMem, 32'h13572468);
      cyc("r63", 1'b0, 1'b1, 7'd63, 32'h0, 1'b0);
      cyc("r64", 1'b0, 1'b1, 7'd64, 32'h0, 1'b0);
      chk("err_sticky_lit", 32'(addr_err), 32'd1);

      // counter saturation
      apply_rst();
      for (int i = 0; i < 20; i++) cyc("sat_rd", 1'b0, 1'b1, 7'($urandom_range(0, 63)), 32'h0, 1'b0);
      chk("sat_rd_lit", 32'(rd_cnt), 32'd15);
      chk("sat_wr_lit", 32'(wr_cnt), 32'd0);

      // randomized traffic with occasional resets
      apply_rst();
      for (int i = 0; i < 600; i++) begin
         logic [6:0] a;
         if ($urandom_range(0, 99) < 2) begin
            apply_rst();
         end else begin
            a = ($urandom_range(0, 3) != 0) ? 7'($urandom_range(0, DEPTH - 1)) : 7'($urandom);
            cyc("rand", ($urandom_range(0, 3) == 0), 1'($urandom), a, $urandom,
                ($urandom_range(0, 4) == 0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder (slave) end of the processor's data-memory interface: a DEPTH-word × 32-bit synchronous SRAM model that accepts the CEN/WEN/A/Data2Mem/OEN request bundle driven by the core and returns ReadDataMem. The block is synchronous with a one-cycle read latency and an output-enable gate. It also keeps read and write access counters and a sticky out-of-range flag for the verification bench. It sits beside the core in the top-level testbench/SoC wrapper, in place of the behavioural memory.

## Interface
Parameters:
- DEPTH, 128, number of implemented words; legal range 1..128. Addresses ≥ DEPTH are out of range.
- CNT_W, 16, width of the access counters.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- CEN  in  1  chip enable, active low; CEN=1 means the cycle is idle.
- WEN  in  1  write enable, active low; 0 = write, 1 = read (valid only when CEN=0).
- A  in  7  word address.
- Data2Mem  in  32  write data.
- OEN  in  1  output enable, active low.
- ReadDataMem  out  32  read data; equals the output register Q when OEN=0, else 32'h0.
- rd_cnt  out  CNT_W  number of accepted read cycles, saturating.
- wr_cnt  out  CNT_W  number of accepted write cycles, saturating.
- addr_err  out  1  sticky flag; set by any enabled access with A ≥ DEPTH.

## Operation
- Storage: array mem[0..DEPTH-1] of 32-bit words, plus a 32-bit output register Q.
- Idle (CEN=1): no change to mem, Q, the counters, or addr_err.
- Read (CEN=0, WEN=1):
  - Q ← mem[A] if A < DEPTH, else Q ← 32'h0.
  - rd_cnt increments.
- Write (CEN=0, WEN=0):
  - mem[A] ← Data2Mem if A < DEPTH; otherwise the write is dropped and no word changes.
  - Q holds its value (no write-through).
  - wr_cnt increments.
- Out of range: any enabled access with A ≥ DEPTH sets addr_err. The flag stays 1 until rst.
  - The access still counts in rd_cnt or wr_cnt.
- Counters: increment by 1 per accepted cycle and saturate at 2^CNT_W−1; they never wrap.
- Output gating:
  - ReadDataMem is combinational from OEN and Q only.
  - OEN does not affect mem, Q, or the counters.
  - OEN=1 forces 0 on ReadDataMem but the Q contents are retained.
- Read-after-write to the same address: the read in the cycle after the write returns the new data, because the array is updated at the write edge.
- Same-edge read and write are impossible, since WEN selects exactly one operation per cycle.
- X handling: if CEN or WEN is X while rst=0, the bench flags an error. The RTL treats the cycle as idle.

## Timing
- Reset (rst=1, asynchronous, takes effect immediately regardless of clk):
  - every mem word = 0; Q = 0; ReadDataMem = 0; rd_cnt = 0; wr_cnt = 0; addr_err = 0.
- Reset mid-operation: an access sampled on the same edge at which rst is high is discarded.
- The first access is taken on the first rising edge with rst=0.
- Read latency: A is sampled at edge N. mem[A] appears on ReadDataMem after edge N, as a registered output, and is valid for the whole cycle N→N+1 (provided OEN=0).
- The core captures the data at edge N+1.
- Write: Data2Mem is sampled at edge N; the array holds it from edge N onward.
- Counters and addr_err update at the same edge as the access they record.
- OEN to ReadDataMem is a combinational path with zero-cycle latency.
- No handshake or stall: every enabled cycle is accepted and there is no backpressure.

## Test plan
- Reset: assert rst mid-cycle after writing mem[5]=32'hDEADBEEF.
  - Required: ReadDataMem, counters, and addr_err read 0 immediately.
  - Required: a later read of A=5 returns 32'h0.
- Write/read: write 32'h12345678 to A=3 at edge 1, then read A=3 at edge 2 with OEN=0.
  - Required: ReadDataMem=32'h12345678 after edge 2; rd_cnt=1; wr_cnt=1.
- Output gating and hold:
  - After the read above, set OEN=1. Required: ReadDataMem=0.
  - Idle 3 cycles (CEN=1), then set OEN=0. Required: ReadDataMem=32'h12345678 again; counters unchanged.
- Write does not disturb Q: read A=3, then write 32'hAAAA5555 to A=7.
  - Required: ReadDataMem stays 32'h12345678.
  - Required: a subsequent read of A=7 returns 32'hAAAA5555.
- Out of range (DEPTH=64):
  - Write 32'hFFFFFFFF to A=100. Required: addr_err=1 after that edge, wr_cnt=1.
  - Read A=100. Required: ReadDataMem=0.
  - Read A=36 (100 mod 64). Required: the value is unchanged, so no aliasing occurred.
  - Required: addr_err stays 1 through later legal accesses.
- Saturation (CNT_W=4): issue 20 back-to-back reads.
  - Required: rd_cnt reaches 15 and holds at 15; wr_cnt=0.
